// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_if
// Description : Register port and SPI pins of the spi_slave peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        spi_clk;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic        int_sig_o;

  modport master (
    output we_i, addr_i, data_i, spi_clk, spi_ss, spi_mosi,
    input  data_o, spi_miso, int_sig_o
  );

  modport slave (
    input  we_i, addr_i, data_i, spi_clk, spi_ss, spi_mosi,
    output data_o, spi_miso, int_sig_o
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : Mode-0 8-bit SPI slave with CPU register port.
//               Optional level interrupt when SPI_SLAVE_INT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_slave_if.slave bus
);

  localparam logic [3:0] c_ADDR_CTRL   = 4'h0;
  localparam logic [3:0] c_ADDR_TXDATA = 4'h4;
  localparam logic [3:0] c_ADDR_RXDATA = 4'h8;
  localparam logic [3:0] c_ADDR_STATUS = 4'hC;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;

  logic       r_en;
  logic       r_int_en;
  logic [7:0] r_tx_buf;
  logic       r_tx_full;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_overrun;
  logic [2:0] r_bit_cnt;
  logic       r_int;

  logic       w_sclk, w_ss, w_mosi, w_busy;
  logic       w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic       w_byte_done, w_load;
  logic [7:0] w_rx_byte;
  logic       w_wr_ctrl, w_wr_tx, w_wr_status;
  logic       w_unused;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_busy = r_en & ~w_ss;

  // SPI edges only count while enabled and selected
  assign w_sclk_rise = w_busy & w_sclk & ~r_sclk_d;
  assign w_sclk_fall = w_busy & ~w_sclk & r_sclk_d;
  assign w_ss_fall   = w_busy & r_ss_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;
  assign w_byte_done = w_sclk_rise & (r_bit_cnt == 3'd7);
  assign w_load      = w_ss_fall | w_byte_done;
  assign w_rx_byte   = {r_rx_shift[6:0], w_mosi};

  assign w_wr_ctrl   = bus.we_i & (bus.addr_i[3:0] == c_ADDR_CTRL);
  assign w_wr_tx     = bus.we_i & (bus.addr_i[3:0] == c_ADDR_TXDATA);
  assign w_wr_status = bus.we_i & (bus.addr_i[3:0] == c_ADDR_STATUS);

  assign w_unused = &{1'b0, bus.addr_i[31:4], bus.data_i[31:8]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
      r_en        <= 1'b0;
      r_int_en    <= 1'b0;
      r_tx_buf    <= 8'h00;
      r_tx_full   <= 1'b0;
      r_tx_shift  <= 8'h00;
      r_rx_shift  <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_int       <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.spi_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;

      if (w_wr_ctrl) begin
        r_en <= bus.data_i[0];
`ifdef SPI_SLAVE_INT_EN
        r_int_en <= bus.data_i[1];
`endif
      end

      // Clears come first so a same-cycle byte completion wins
      if (w_wr_status) begin
        if (bus.data_i[0]) r_rx_valid <= 1'b0;
        if (bus.data_i[3]) r_overrun  <= 1'b0;
      end

      if (w_sclk_rise) begin
        r_rx_shift <= w_rx_byte;
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end

      if (w_byte_done) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
        if (r_rx_valid) r_overrun <= 1'b1;
      end

      if (w_sclk_fall && (r_bit_cnt != 3'd0))
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};

      if (w_load) begin
        if (r_tx_full) begin
          r_tx_shift <= r_tx_buf;
          r_tx_full  <= 1'b0;
        end else begin
          r_tx_shift <= 8'h00;
        end
      end

      // Placed after the load so a same-cycle write leaves the new byte pending
      if (w_wr_tx) begin
        r_tx_buf  <= bus.data_i[7:0];
        r_tx_full <= 1'b1;
      end

      if (!r_en || w_ss_rise)
        r_bit_cnt <= 3'd0;

`ifdef SPI_SLAVE_INT_EN
      r_int <= r_int_en & (r_rx_valid | r_overrun);
`endif
    end
  end

  always_comb begin
    bus.data_o = 32'h0;
    case (bus.addr_i[3:0])
      c_ADDR_CTRL:   bus.data_o = {30'h0, r_int_en, r_en};
      c_ADDR_TXDATA: bus.data_o = {24'h0, r_tx_buf};
      c_ADDR_RXDATA: bus.data_o = {24'h0, r_rx_data};
      c_ADDR_STATUS: bus.data_o = {28'h0, r_overrun, w_busy, r_tx_full, r_rx_valid};
      default:       bus.data_o = 32'h0;
    endcase
  end

  assign bus.spi_miso  = w_busy & r_tx_shift[7];
  assign bus.int_sig_o = r_int;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Directed self-checking bench for spi_slave (sclk = clk/8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spi_slave_if bus ();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
    bus.we_i   = 1'b1;
    bus.addr_i = {28'h0, addr};
    bus.data_i = data;
    @(negedge clk);
    bus.we_i   = 1'b0;
    bus.data_i = 32'h0;
  endtask

  task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
    bus.addr_i = {28'h0, addr};
    #1;
    data = bus.data_o;
  endtask

  // Master side: drive MOSI while sclk low, sample MISO at the rising pin edge
  task automatic spi_shift(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = tx[7-i];
      wait_clk(4);
      bus.spi_clk = 1'b1;
      rx = {rx[6:0], bus.spi_miso};
      wait_clk(4);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic spi_select();
    bus.spi_ss = 1'b0;
  endtask

  task automatic spi_deselect();
    wait_clk(4);
    bus.spi_ss   = 1'b1;
    bus.spi_mosi = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(1);
    for (int a = 0; a < 16; a += 4) begin
      reg_read(a[3:0], d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg[%0h]: got %h expected %h", a, d, 32'h0);
      end
    end
    checks++;
    if (bus.spi_miso !== 1'b0) begin
      errors++;
      $display("FAIL reset_miso: got %b expected 0", bus.spi_miso);
    end
    checks++;
    if (bus.int_sig_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_int: got %b expected 0", bus.int_sig_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [7:0]  rx;
    reg_write(4'h0, 32'h1);
    reg_write(4'h4, 32'hA5);
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL basic_status_txfull: got %h expected %h", d, 32'h2);
    end
    spi_select();
    spi_shift(8'h3C, 8, rx);
    checks++;
    if (rx !== 8'hA5) begin
      errors++;
      $display("FAIL basic_miso_byte: got %h expected %h", rx, 8'hA5);
    end
    reg_read(4'h8, d);
    checks++;
    if (d !== 32'h3C) begin
      errors++;
      $display("FAIL basic_rxdata: got %h expected %h", d, 32'h3C);
    end
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL basic_status_busy: got %h expected %h", d, 32'h5);
    end
    spi_deselect();
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL basic_status_idle: got %h expected %h", d, 32'h1);
    end
    reg_write(4'hC, 32'h1);
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL basic_status_clear: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_int();
    logic [31:0] d;
    logic [7:0]  rx;
    reg_write(4'h0, 32'h3);
    reg_read(4'h0, d);
`ifdef SPI_SLAVE_INT_EN
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL int_ctrl_read: got %h expected %h", d, 32'h3);
    end
    spi_select();
    spi_shift(8'h55, 8, rx);
    spi_deselect();
    checks++;
    if (bus.int_sig_o !== 1'b1) begin
      errors++;
      $display("FAIL int_asserted: got %b expected 1", bus.int_sig_o);
    end
    reg_write(4'hC, 32'h1);
    checks++;
    if (bus.int_sig_o !== 1'b1) begin
      errors++;
      $display("FAIL int_lag: got %b expected 1", bus.int_sig_o);
    end
    wait_clk(1);
    checks++;
    if (bus.int_sig_o !== 1'b0) begin
      errors++;
      $display("FAIL int_cleared: got %b expected 0", bus.int_sig_o);
    end
`else
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL int_ctrl_read: got %h expected %h", d, 32'h1);
    end
    spi_select();
    spi_shift(8'h55, 8, rx);
    spi_deselect();
    checks++;
    if (bus.int_sig_o !== 1'b0) begin
      errors++;
      $display("FAIL int_tied_low: got %b expected 0", bus.int_sig_o);
    end
    reg_write(4'hC, 32'h1);
`endif
    reg_read(4'h8, d);
    checks++;
    if (d !== 32'h55) begin
      errors++;
      $display("FAIL int_rxdata: got %h expected %h", d, 32'h55);
    end
    reg_write(4'h0, 32'h1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  rx;
    logic [7:0]  tx_bytes [3];
    logic [7:0]  exp_miso [3];
    tx_bytes = '{8'h11, 8'h22, 8'h33};
    exp_miso = '{8'hC3, 8'h00, 8'h00};
    reg_write(4'h4, 32'hC3);
    spi_select();
    for (int b = 0; b < 3; b++) begin
      spi_shift(tx_bytes[b], 8, rx);
      checks++;
      if (rx !== exp_miso[b]) begin
        errors++;
        $display("FAIL burst_miso[%0d]: got %h expected %h", b, rx, exp_miso[b]);
      end
    end
    spi_deselect();
    reg_read(4'h8, d);
    checks++;
    if (d !== 32'h33) begin
      errors++;
      $display("FAIL burst_rxdata: got %h expected %h", d, 32'h33);
    end
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h9) begin
      errors++;
      $display("FAIL burst_status_overrun: got %h expected %h", d, 32'h9);
    end
    reg_write(4'hC, 32'h9);
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL burst_status_clear: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic [7:0]  rx;
    spi_select();
    spi_shift(8'hFF, 5, rx);
    spi_deselect();
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL abort_no_valid: got %h expected %h", d, 32'h0);
    end
    spi_select();
    spi_shift(8'h81, 8, rx);
    spi_deselect();
    reg_read(4'h8, d);
    checks++;
    if (d !== 32'h81) begin
      errors++;
      $display("FAIL abort_rxdata: got %h expected %h", d, 32'h81);
    end
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL abort_status: got %h expected %h", d, 32'h1);
    end
    reg_write(4'hC, 32'h1);
  endtask

  task automatic test_disabled();
    logic [31:0] d;
    logic [7:0]  rx;
    reg_write(4'h0, 32'h0);
    reg_write(4'h4, 32'h5A);
    spi_select();
    spi_shift(8'h77, 8, rx);
    checks++;
    if (rx !== 8'h00) begin
      errors++;
      $display("FAIL disabled_miso: got %h expected %h", rx, 8'h00);
    end
    spi_deselect();
    reg_read(4'h8, d);
    checks++;
    if (d !== 32'h81) begin
      errors++;
      $display("FAIL disabled_rxdata: got %h expected %h", d, 32'h81);
    end
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL disabled_status: got %h expected %h", d, 32'h2);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    logic [7:0]  rx;
    reg_write(4'h0, 32'h1);
    spi_select();
    spi_shift(8'hF0, 3, rx);
    bus.spi_clk = 1'b1;
    wait_clk(2);
    rst_n = 1'b0;
    wait_clk(2);
    bus.spi_clk  = 1'b0;
    bus.spi_ss   = 1'b1;
    bus.spi_mosi = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(1);
    for (int a = 0; a < 16; a += 4) begin
      reg_read(a[3:0], d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL midreset_reg[%0h]: got %h expected %h", a, d, 32'h0);
      end
    end
    reg_write(4'h0, 32'h1);
    spi_select();
    spi_shift(8'h96, 8, rx);
    checks++;
    if (rx !== 8'h00) begin
      errors++;
      $display("FAIL midreset_miso: got %h expected %h", rx, 8'h00);
    end
    spi_deselect();
    reg_read(4'h8, d);
    checks++;
    if (d !== 32'h96) begin
      errors++;
      $display("FAIL midreset_rxdata: got %h expected %h", d, 32'h96);
    end
    reg_read(4'hC, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL midreset_status: got %h expected %h", d, 32'h1);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.we_i     = 1'b0;
    bus.addr_i   = 32'h0;
    bus.data_i   = 32'h0;
    bus.spi_clk  = 1'b0;
    bus.spi_ss   = 1'b1;
    bus.spi_mosi = 1'b0;
    wait_clk(2);
    test_reset();
    test_basic();
    test_int();
    test_back_to_back();
    test_abort();
    test_disabled();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
# spi_slave

SPI slave responder: the far end of the SoC SPI master link, so a second rooth SoC, or the bench, can act as an SPI target. Receives 8-bit mode-0 frames on `spi_clk`/`spi_ss`/`spi_mosi` and returns a CPU-loaded byte on `spi_miso`. Sits as a RIB slave peripheral beside timer/uart/gpio/spi, with the same `we_i`/`addr_i`/`data_i`/`data_o` register port and an optional level interrupt for `int_flag_i`.

## Interface
- `SYNC_STAGES`, default 2: flops in each SPI input synchronizer (minimum 2).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `we_i`  in  1  register write strobe.
- `addr_i`  in  32  register address; only `addr_i[3:0]` decoded.
- `data_i`  in  32  register write data.
- `data_o`  out  32  register read data; combinational from `addr_i`.
- `spi_clk`  in  1  SPI clock from master; asynchronous.
- `spi_ss`  in  1  chip select, active low; asynchronous.
- `spi_mosi`  in  1  master-out data.
- `spi_miso`  out  1  slave-out data; 0 when not selected or disabled.
- `int_sig_o`  out  1  level interrupt.

## Operation
- Registers:
  - 0x0 CTRL: [0] `en`, [1] `int_en`.
  - 0x4 TXDATA: write sets `tx_buf` to `data_i[7:0]` and sets `tx_full`. Reads return `{24'h0, tx_buf}`.
  - 0x8 RXDATA: read-only, `{24'h0, rx_data}`.
  - 0xC STATUS: [0] `rx_valid`, [1] `tx_full`, [2] `busy`, [3] `overrun`. Writing 1 to bit 0 or bit 3 clears that bit; other bits are read-only.
  - Unmapped addresses read 0.
- SPI format: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. Back-to-back bytes are allowed while `ss` stays low.
- Input synchronization: `spi_clk`, `spi_ss` and `spi_mosi` each pass through a `SYNC_STAGES` synchronizer. One further flop on `sclk` and on `ss` provides edge detection.
- `busy` = `en` and synchronized `ss` low.
- Byte load (tx side):
  - Trigger: `ss` fall or completion of a byte.
  - If `tx_full`, the shift register loads `tx_buf` and `tx_full` clears.
  - Otherwise the shift register loads 0x00.
  - `spi_miso` = `tx_shift[7]` while `busy`.
- Synchronized `sclk` rising edge:
  - `rx_shift` ← `{rx_shift[6:0], mosi}` and `bit_cnt`++ (3-bit, wraps).
  - When `bit_cnt` wraps 7→0: `rx_data` ← completed byte, `rx_valid` ← 1, and the next byte loads.
  - If `rx_valid` was already 1, `overrun` ← 1 and `rx_data` is still overwritten.
- Synchronized `sclk` falling edge: if `bit_cnt` ≠ 0, `tx_shift` ← `{tx_shift[6:0], 0}`. The bit count is 0 right after a load, so bit 7 is held.
- `ss` rise mid-byte: `bit_cnt` ← 0 and the partial byte is discarded (no `rx_valid`). The loaded TX byte is lost; `tx_full` stays as is.
- `en` = 0: SPI edges are ignored, `bit_cnt` is held at 0, `spi_miso` = 0 and `busy` = 0. Register access is unaffected.
- Simultaneous events:
  - Byte completion in the same cycle as a STATUS write-1-clear: the set wins.
  - TXDATA write in the same cycle as a load: the load uses the old `tx_buf`/`tx_full` state, and the write then leaves `tx_full` = 1 holding the new byte.
  - TXDATA write while `tx_full`: overwrites, no error flag.

## Timing
- Reset: all registers 0, `tx_buf` 0, shift registers 0, `bit_cnt` 0. Synchronizers go to idle (`ss`=1, `sclk`=0, `mosi`=0). `spi_miso` = 0, `int_sig_o` = 0, `data_o` reflects the reset registers.
- Reset mid-frame: the frame is abandoned. The block responds again from the next `ss` fall after reset release.
- Pin-to-action latency is `SYNC_STAGES`+1 clk edges.
- `rx_valid` and `int_sig_o` are visible on the clk after the registered 8th rising edge.
- Master constraints:
  - `spi_clk` high and low times ≥ `SYNC_STAGES`+2 clk each; ≥ 4 clk each at the default.
  - `ss` fall to first `sclk` rise ≥ `SYNC_STAGES`+2 clk.
- MISO changes `SYNC_STAGES`+1 clk after the pin-level falling edge and is stable before the next rising edge under the constraints above.
- Register writes take effect on the next clk edge; reads are combinational.

## Configuration
- `SPI_SLAVE_INT_EN` defined: `int_sig_o` = `int_en` & (`rx_valid` | `overrun`), registered, so it updates one clk after the flag changes.
- `SPI_SLAVE_INT_EN` undefined: `int_sig_o` is tied to 0, CTRL[1] is not stored and reads 0, and all other behaviour is identical.

## Test plan
- Reset, then read all four addresses → all 0, `spi_miso` = 0, `int_sig_o` = 0.
- CTRL=0x1, TXDATA=0xA5, master sends 0x3C (`sclk` = clk/8) → master receives 0xA5, RXDATA=0x3C, STATUS=0x5 during `ss` low, STATUS=0x1 after `ss` rises.
- Three-byte burst 0x11, 0x22, 0x33 with TXDATA 0xC3 loaded only before the first byte → MISO bytes 0xC3, 0x00, 0x00; RXDATA=0x33; STATUS[3]=1; write STATUS=0x9 → STATUS=0x0.
- `ss` rises after 5 bits, then a full byte 0x81 → only 0x81 is captured, with a single `rx_valid` set.
- With the macro on, CTRL=0x3, byte received → `int_sig_o` = 1; write STATUS=0x1 → `int_sig_o` = 0 next clk. With the macro off → `int_sig_o` stays 0 and CTRL reads 0x1.
- CTRL=0x0, master clocks a byte → no RX, `spi_miso` = 0. Assert reset mid-byte with CTRL=0x1 → all state is 0 and the next full byte is received correctly.
